// File: rtl/neuron_seq_backprop_if.sv
// ---------------------------------------------------------------------------
// neuron_seq_backprop_if
// Bundles the handshake, weight-port and result signals of one
// neuron_seq_backprop instance. The sequencer (or bench) uses the master
// modport. The neuron uses the slave modport.
//
//   start_i      begin an operation (sampled only while idle)
//   train_i      forward only (0) or forward plus weight update (1)
//   is_output_i  error taken from target (1) or from err_in (0)
//   x_in_i       packed inputs, x_i = x_in_i[i*W +: W]
//   target_i     desired output for an output-layer neuron
//   err_in_i     summed backprop term from the downstream layer
//   step_i       learning rate
//   wr_en_i      weight write strobe, wr_addr_i / wr_data_i
//   rd_addr_i    weight read index, rd_data_o combinational read data
//   busy_o       high whenever the neuron is not idle
//   done_o       one-cycle pulse when results are valid
//   y_o          neuron output
//   delta_o      local gradient term after a training pass
//   bp_out_o     packed delta*w_i terms for the upstream layer
// ---------------------------------------------------------------------------
interface neuron_seq_backprop_if #(
    parameter int N_IN = 4,
    parameter int W    = 32,
    parameter int AW   = $clog2(N_IN + 1)
);
    logic                 start_i;
    logic                 train_i;
    logic                 is_output_i;
    logic [N_IN*W-1:0]    x_in_i;
    logic [W-1:0]         target_i;
    logic [W-1:0]         err_in_i;
    logic [W-1:0]         step_i;
    logic                 wr_en_i;
    logic [AW-1:0]        wr_addr_i;
    logic [W-1:0]         wr_data_i;
    logic [AW-1:0]        rd_addr_i;
    logic [W-1:0]         rd_data_o;
    logic                 busy_o;
    logic                 done_o;
    logic [W-1:0]         y_o;
    logic [W-1:0]         delta_o;
    logic [N_IN*W-1:0]    bp_out_o;

    // The master drives commands and weight writes, and it observes results.
    modport master (
        output start_i, train_i, is_output_i, x_in_i, target_i, err_in_i,
               step_i, wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        input  rd_data_o, busy_o, done_o, y_o, delta_o, bp_out_o
    );

    // The neuron itself.
    modport slave (
        input  start_i, train_i, is_output_i, x_in_i, target_i, err_in_i,
               step_i, wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        output rd_data_o, busy_o, done_o, y_o, delta_o, bp_out_o
    );
endinterface

// File: rtl/neuron_seq_backprop.sv
// ---------------------------------------------------------------------------
// neuron_seq_backprop
// A single neuron with N_IN inputs. All inputs share one MAC over several
// cycles. The neuron computes the weighted sum plus bias, applies a hard
// sigmoid, and can then run one gradient-descent step on its own weights
// and bias. All data is signed fixed point with FRAC fractional bits.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset. It clears the weights, the
//          results and the FSM.
//   bus    neuron_seq_backprop_if.slave. This port carries the
//          start/train/target/error/step controls, the weight read/write
//          port and the y/delta/bp_out/busy/done results.
//
// Configuration macro
//   NEURON_SAT_EN  When defined, every product and every add/sub saturates
//                  to the W-bit signed range. When undefined, results wrap
//                  in two's complement.
//
// Timing (cycle 0 = idle cycle with start high)
//   MAC occupies cycles 1..N_IN and ACT occupies cycle N_IN+1.
//   Forward: done in cycle N_IN+2.
//   Train:   DELTA, then UPD for N_IN+1 cycles. Done in cycle 2*N_IN+4.
// ---------------------------------------------------------------------------
module neuron_seq_backprop #(
    parameter int N_IN = 4,
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int AW   = $clog2(N_IN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    neuron_seq_backprop_if.slave  bus
);

    localparam logic signed [W-1:0] ONE  = {{(W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [W-1:0] HALF = {{(W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`ifdef NEURON_SAT_EN
    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        ACT,
        DELTA,
        UPD,
        DONE
    } state_t;

    // Fixed-point add. It saturates or wraps, depending on the build.
    function automatic logic signed [W-1:0] fxAdd(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
`ifdef NEURON_SAT_EN
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) begin
            return s[W] ? MINV : MAXV;
        end
        return s[W-1:0];
`else
        return a + b;
`endif
    endfunction

    // Fixed-point subtract. Overflow is handled the same way as in fxAdd.
    function automatic logic signed [W-1:0] fxSub(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
`ifdef NEURON_SAT_EN
        logic [W:0] s;
        s = {a[W-1], a} - {b[W-1], b};
        if (s[W] != s[W-1]) begin
            return s[W] ? MINV : MAXV;
        end
        return s[W-1:0];
`else
        return a - b;
`endif
    endfunction

    // Fixed-point multiply. The function forms the full-width signed product
    // and drops FRAC bits with an arithmetic shift, which rounds toward minus
    // infinity. It then keeps W bits, either saturating or wrapping.
    function automatic logic signed [W-1:0] fxMul(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
`ifdef NEURON_SAT_EN
        logic signed [2*W-1:0] prod;
        logic signed [2*W-1:0] sh;
        prod = a * b;
        sh   = prod >>> FRAC;
        if (sh[2*W-1:W-1] == {(W+1){1'b0}} || sh[2*W-1:W-1] == {(W+1){1'b1}}) begin
            return sh[W-1:0];
        end
        return sh[2*W-1] ? MINV : MAXV;
`else
        logic signed [2*W-1:0] prod;
        prod = a * b;
        return prod[W-1+FRAC:FRAC];
`endif
    endfunction

    state_t state_q, state_d;

    logic signed [W-1:0] weight_q [N_IN+1];
    logic signed [W-1:0] weight_d [N_IN+1];
    logic signed [W-1:0] xVec_q   [N_IN];
    logic signed [W-1:0] xVec_d   [N_IN];
    logic signed [W-1:0] bp_q     [N_IN];
    logic signed [W-1:0] bp_d     [N_IN];
    logic signed [W-1:0] acc_q, acc_d;
    logic signed [W-1:0] y_q, y_d;
    logic signed [W-1:0] delta_q, delta_d;
    logic signed [W-1:0] target_q, target_d;
    logic signed [W-1:0] errIn_q, errIn_d;
    logic signed [W-1:0] step_q, step_d;
    logic                train_q, train_d;
    logic                isOutput_q, isOutput_d;
    logic [AW-1:0]       idx_q, idx_d;

    logic signed [W-1:0] curW;
    logic signed [W-1:0] curX;
    logic [W-1:0]        rdData;
    logic signed [W-1:0] macBase;
    logic signed [W-1:0] macProd;
    logic signed [W-1:0] actSum;
    logic signed [W-1:0] yNext;
    logic signed [W-1:0] errVal;
    logic signed [W-1:0] yTerm;
    logic signed [W-1:0] deltaNext;
    logic signed [W-1:0] stepDelta;
    logic signed [W-1:0] updW;
    logic signed [W-1:0] bpNext;
    logic [N_IN*W-1:0]   bpFlat;
    logic                busyO;
    logic                doneO;
    logic                lastMac;
    logic                lastUpd;

    assign lastMac = (idx_q == AW'(N_IN - 1));
    assign lastUpd = (idx_q == AW'(N_IN));

    // State register. A reset drops any operation in flight and returns
    // the FSM to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The FSM accepts start only in IDLE, so a start
    // pulse during the sequence (including the DONE cycle) has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = MAC;
            MAC:     if (lastMac) state_d = ACT;
            ACT:     state_d = train_q ? DELTA : DONE;
            DELTA:   state_d = UPD;
            UPD:     if (lastUpd) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. done_o is high only in DONE.
    always_comb begin
        busyO = (state_q != IDLE);
        doneO = (state_q == DONE);
    end

    // The shared index selects the current weight and input. The same
    // muxes also form the combinational weight read port. Reads of
    // addresses above the bias return zero.
    always_comb begin
        curW   = '0;
        curX   = '0;
        rdData = '0;
        for (int k = 0; k <= N_IN; k++) begin
            if (idx_q == AW'(k)) curW = weight_q[k];
            if (bus.rd_addr_i == AW'(k)) rdData = weight_q[k];
        end
        for (int k = 0; k < N_IN; k++) begin
            if (idx_q == AW'(k)) curX = xVec_q[k];
        end
    end

    // Arithmetic for each phase.
    // - The first MAC cycle seeds the accumulator with the bias.
    // - The hard sigmoid is 0.5 + acc/4, clamped to [0, 1.0].
    // - The bias update uses step*delta directly, because the bias has
    //   no input term.
    always_comb begin
        macBase   = (idx_q == '0) ? weight_q[N_IN] : acc_q;
        macProd   = fxMul(curX, curW);
        actSum    = fxAdd(HALF, acc_q >>> 2);
        if (actSum[W-1]) begin
            yNext = '0;
        end else if (actSum > ONE) begin
            yNext = ONE;
        end else begin
            yNext = actSum;
        end
        errVal    = isOutput_q ? fxSub(y_q, target_q) : errIn_q;
        yTerm     = fxMul(y_q, fxSub(ONE, y_q));
        deltaNext = fxMul(errVal, yTerm);
        stepDelta = fxMul(step_q, delta_q);
        updW      = lastUpd ? fxSub(curW, stepDelta)
                            : fxSub(curW, fxMul(stepDelta, curX));
        bpNext    = fxMul(delta_q, curW);
    end

    // Datapath next-state logic.
    // - In IDLE, a host weight write lands at the same edge that accepts
    //   start, so the first MAC cycle already uses the new value.
    // - During UPD, bp_out reads the weight before it is overwritten,
    //   which gives the pre-update weight.
    always_comb begin
        weight_d   = weight_q;
        xVec_d     = xVec_q;
        bp_d       = bp_q;
        acc_d      = acc_q;
        y_d        = y_q;
        delta_d    = delta_q;
        target_d   = target_q;
        errIn_d    = errIn_q;
        step_d     = step_q;
        train_d    = train_q;
        isOutput_d = isOutput_q;
        idx_d      = idx_q;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (bus.wr_en_i) begin
                    for (int k = 0; k <= N_IN; k++) begin
                        if (bus.wr_addr_i == AW'(k)) weight_d[k] = bus.wr_data_i;
                    end
                end
                if (bus.start_i) begin
                    for (int k = 0; k < N_IN; k++) begin
                        xVec_d[k] = bus.x_in_i[k*W +: W];
                    end
                    target_d   = bus.target_i;
                    errIn_d    = bus.err_in_i;
                    step_d     = bus.step_i;
                    train_d    = bus.train_i;
                    isOutput_d = bus.is_output_i;
                end
            end
            MAC: begin
                acc_d = fxAdd(macBase, macProd);
                idx_d = lastMac ? '0 : idx_q + 1'b1;
            end
            ACT: begin
                y_d   = yNext;
                idx_d = '0;
            end
            DELTA: begin
                delta_d = deltaNext;
            end
            UPD: begin
                for (int k = 0; k <= N_IN; k++) begin
                    if (idx_q == AW'(k)) weight_d[k] = updW;
                end
                for (int k = 0; k < N_IN; k++) begin
                    if (idx_q == AW'(k)) bp_d[k] = bpNext;
                end
                idx_d = idx_q + 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers. A reset clears the weights and results, which
    // discards any partly applied update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= N_IN; k++) weight_q[k] <= '0;
            for (int k = 0; k < N_IN; k++) begin
                xVec_q[k] <= '0;
                bp_q[k]   <= '0;
            end
            acc_q      <= '0;
            y_q        <= '0;
            delta_q    <= '0;
            target_q   <= '0;
            errIn_q    <= '0;
            step_q     <= '0;
            train_q    <= 1'b0;
            isOutput_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            weight_q   <= weight_d;
            xVec_q     <= xVec_d;
            bp_q       <= bp_d;
            acc_q      <= acc_d;
            y_q        <= y_d;
            delta_q    <= delta_d;
            target_q   <= target_d;
            errIn_q    <= errIn_d;
            step_q     <= step_d;
            train_q    <= train_d;
            isOutput_q <= isOutput_d;
            idx_q      <= idx_d;
        end
    end

    // Pack the per-input backprop terms into the flat output bus.
    always_comb begin
        bpFlat = '0;
        for (int k = 0; k < N_IN; k++) begin
            bpFlat[k*W +: W] = bp_q[k];
        end
    end

    assign bus.rd_data_o = rdData;
    assign bus.busy_o    = busyO;
    assign bus.done_o    = doneO;
    assign bus.y_o       = y_q;
    assign bus.delta_o   = delta_q;
    assign bus.bp_out_o  = bpFlat;

endmodule

// File: tb/tb_neuron_seq_backprop.sv
// ---------------------------------------------------------------------------
// tb_neuron_seq_backprop
// Directed bench for neuron_seq_backprop with N_IN=2, W=32, FRAC=16.
// Every expected value is a hand-computed fixed-point constant.
// ---------------------------------------------------------------------------
module tb_neuron_seq_backprop;

    localparam int N_IN = 2;
    localparam int W    = 32;
    localparam int FRAC = 16;
    localparam int AW   = $clog2(N_IN + 1);

    logic clk;
    logic rst_n;

    int assertCount = 0;
    int failCount   = 0;

    int          doneCycle;
    logic [15:0] busyMask;
    logic [15:0] doneMask;
    logic [31:0] expSat;

    neuron_seq_backprop_if #(.N_IN(N_IN), .W(W), .AW(AW)) bus ();

    neuron_seq_backprop #(.N_IN(N_IN), .W(W), .FRAC(FRAC), .AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10-unit clock. The bench drives and samples on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The single comparison point. It counts every check and reports any
    // mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Read back the three weight slots through the combinational read port.
    task automatic checkWeights(input string tag, input logic [31:0] e0,
                                input logic [31:0] e1, input logic [31:0] eb);
        bus.rd_addr_i = 2'd0; #1;
        checkOutput({tag, ".w0"}, 64'(bus.rd_data_o), 64'(e0));
        bus.rd_addr_i = 2'd1; #1;
        checkOutput({tag, ".w1"}, 64'(bus.rd_data_o), 64'(e1));
        bus.rd_addr_i = 2'd2; #1;
        checkOutput({tag, ".b"}, 64'(bus.rd_data_o), 64'(eb));
    endtask

    // Write one weight slot while the neuron is idle.
    task automatic writeWeight(input logic [AW-1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = addr;
        bus.wr_data_i = data;
        @(negedge clk);
        bus.wr_en_i   = 1'b0;
    endtask

    // Launch one operation and observe a fixed 15-cycle window.
    // - After cycle 0, the task scrambles the operands so that a design
    //   that fails to capture them on start gives a wrong result.
    // - startMask re-raises start in chosen cycles; those pulses must be
    //   ignored.
    // - The task records busy and done for each cycle.
    task automatic applyStimulus(input logic tr, input logic isOut,
                                 input logic [31:0] x0, input logic [31:0] x1,
                                 input logic [31:0] tgt, input logic [31:0] errIn,
                                 input logic [31:0] stp, input logic [15:0] startMask,
                                 input logic wrEn, input logic [AW-1:0] wrAddr,
                                 input logic [31:0] wrData,
                                 output int dCycle, output logic [15:0] bMask,
                                 output logic [15:0] dMask);
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.train_i     = tr;
        bus.is_output_i = isOut;
        bus.x_in_i      = {x1, x0};
        bus.target_i    = tgt;
        bus.err_in_i    = errIn;
        bus.step_i      = stp;
        bus.wr_en_i     = wrEn;
        bus.wr_addr_i   = wrAddr;
        bus.wr_data_i   = wrData;
        dCycle = -1;
        bMask  = '0;
        dMask  = '0;
        for (int c = 1; c < 16; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.wr_en_i     = 1'b0;
            bus.x_in_i      = {2{32'h0003_0000}};
            bus.target_i    = 32'h0000_0007;
            bus.err_in_i    = 32'h0000_0007;
            bus.step_i      = 32'h0000_0007;
            bus.train_i     = ~tr;
            bus.is_output_i = ~isOut;
            bus.start_i     = startMask[c];
            bMask[c] = bus.busy_o;
            dMask[c] = bus.done_o;
            if (bus.done_o && dCycle < 0) dCycle = c;
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.train_i     = 1'b0;
        bus.is_output_i = 1'b0;
        bus.x_in_i      = '0;
        bus.target_i    = '0;
        bus.err_in_i    = '0;
        bus.step_i      = '0;
        bus.wr_en_i     = 1'b0;
        bus.wr_addr_i   = '0;
        bus.wr_data_i   = '0;
        bus.rd_addr_i   = '0;

        // Check the state held during reset.
        repeat (2) @(negedge clk);
        checkOutput("reset.busy", 64'(bus.busy_o), 64'd0);
        checkOutput("reset.done", 64'(bus.done_o), 64'd0);
        checkOutput("reset.y", 64'(bus.y_o), 64'd0);
        checkOutput("reset.delta", 64'(bus.delta_o), 64'd0);
        checkOutput("reset.bp", 64'(bus.bp_out_o), 64'd0);
        checkWeights("reset", 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Forward pass with all-zero weights: y = 0.5.
        applyStimulus(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0,
                      16'h0, 1'b0, 2'd0, 32'h0, doneCycle, busyMask, doneMask);
        checkOutput("fwd0.doneCycle", 64'(doneCycle), 64'd4);
        checkOutput("fwd0.busyMask", 64'(busyMask), 64'h001E);
        checkOutput("fwd0.doneMask", 64'(doneMask), 64'h0010);
        checkOutput("fwd0.y", 64'(bus.y_o), 64'h0000_8000);

        // Mixed weights with a bias: acc = 0.5 + 1.0 - 0.5 = 1.0, so y = 0.75.
        writeWeight(2'd0, 32'h0001_0000);
        writeWeight(2'd1, 32'hFFFF_0000);
        writeWeight(2'd2, 32'h0000_8000);
        checkWeights("wr1", 32'h0001_0000, 32'hFFFF_0000, 32'h0000_8000);
        applyStimulus(1'b0, 1'b0, 32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0, 32'h0,
                      16'h0, 1'b0, 2'd0, 32'h0, doneCycle, busyMask, doneMask);
        checkOutput("fwd1.doneCycle", 64'(doneCycle), 64'd4);
        checkOutput("fwd1.y", 64'(bus.y_o), 64'h0000_C000);

        // Clamp at the top: acc = 4.0 gives 1.5, clamped to 1.0.
        writeWeight(2'd0, 32'h0004_0000);
        writeWeight(2'd1, 32'h0);
        writeWeight(2'd2, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                      16'h0, 1'b0, 2'd0, 32'h0, doneCycle, busyMask, doneMask);
        checkOutput("clampHi.y", 64'(bus.y_o), 64'h0001_0000);

        // Clamp at the bottom: acc = -4.0 gives -0.5, clamped to 0.
        writeWeight(2'd0, 32'hFFFC_0000);
        applyStimulus(1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                      16'h0, 1'b0, 2'd0, 32'h0, doneCycle, busyMask, doneMask);
        checkOutput("clampLo.y", 64'(bus.y_o), 64'h0);

        // Output-layer training step from zero weights:
        // err = -0.5, y(1-y) = 0.25, delta = -0.125, new w0 = b = +0.125.
        writeWeight(2'd0, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0, 32'h0001_0000,
                      16'h0, 1'b0, 2'd0, 32'h0, doneCycle, busyMask, doneMask);
        checkOutput("trainOut.doneCycle", 64'(doneCycle), 64'd8);
        checkOutput("trainOut.busyMask", 64'(busyMask), 64'h01FE);
        checkOutput("trainOut.doneMask", 64'(doneMask), 64'h0100);
        checkOutput("trainOut.y", 64'(bus.y_o), 64'h0000_8000);
        checkOutput("trainOut.delta", 64'(bus.delta_o), 64'hFFFF_E000);
        checkOutput("trainOut.bp", 64'(bus.bp_out_o), 64'h0);
        checkWeights("trainOut", 32'h0000_2000, 32'h0, 32'h0000_2000);

        // Hidden-layer training step: w = (0.125, 1.0), b = 0.125, x = (1.0, 0.5),
        // err_in = 1.0, step = 0.5.
        //   acc = 0.75 and y = 0.6875 (0xB000). y(1-y) = 0x3700, so delta = 0x3700.
        //   bp = (0x3700*0.125, 0x3700*1.0) = (0x6E0, 0x3700).
        //   step*delta = 0x1B80, so w0 = 0x480, w1 = 0x10000-0xDC0 = 0xF240, b = 0x480.
        writeWeight(2'd1, 32'h0001_0000);
        applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0001_0000,
                      32'h0000_8000, 16'h0, 1'b0, 2'd0, 32'h0, doneCycle, busyMask, doneMask);
        checkOutput("trainHid.doneCycle", 64'(doneCycle), 64'd8);
        checkOutput("trainHid.y", 64'(bus.y_o), 64'h0000_B000);
        checkOutput("trainHid.delta", 64'(bus.delta_o), 64'h0000_3700);
        checkOutput("trainHid.bp0", 64'(bus.bp_out_o[31:0]), 64'h0000_06E0);
        checkOutput("trainHid.bp1", 64'(bus.bp_out_o[63:32]), 64'h0000_3700);
        checkWeights("trainHid", 32'h0000_0480, 32'h0000_F240, 32'h0000_0480);

        // Overflowing product: 0x7FFF0000 * 2.0 either saturates or wraps to -2.0.
`ifdef NEURON_SAT_EN
        expSat = 32'h0001_0000;
`else
        expSat = 32'h0000_0000;
`endif
        writeWeight(2'd0, 32'h7FFF_0000);
        writeWeight(2'd1, 32'h0);
        writeWeight(2'd2, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0002_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                      16'h0, 1'b0, 2'd0, 32'h0, doneCycle, busyMask, doneMask);
        checkOutput("ovf.y", 64'(bus.y_o), 64'(expSat));

        // A start pulse during MAC must be ignored.
        writeWeight(2'd0, 32'h0001_0000);
        applyStimulus(1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                      16'h0002, 1'b0, 2'd0, 32'h0, doneCycle, busyMask, doneMask);
        checkOutput("midStart.doneCycle", 64'(doneCycle), 64'd4);
        checkOutput("midStart.busyMask", 64'(busyMask), 64'h001E);
        checkOutput("midStart.doneMask", 64'(doneMask), 64'h0010);
        checkOutput("midStart.y", 64'(bus.y_o), 64'h0000_C000);

        // A start pulse in the DONE cycle must not launch a new operation.
        applyStimulus(1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                      16'h0010, 1'b0, 2'd0, 32'h0, doneCycle, busyMask, doneMask);
        checkOutput("doneStart.busyMask", 64'(busyMask), 64'h001E);
        checkOutput("doneStart.doneMask", 64'(doneMask), 64'h0010);

        // A write in the same cycle as start must be visible to the MAC.
        writeWeight(2'd0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                      16'h0, 1'b1, 2'd0, 32'h0001_0000, doneCycle, busyMask, doneMask);
        checkOutput("wrStart.y", 64'(bus.y_o), 64'h0000_C000);

        // A write to an address past the bias must be ignored.
        writeWeight(2'd3, 32'h1234_5678);
        checkWeights("wrOob", 32'h0001_0000, 32'h0, 32'h0);

        // Reset during UPD (cycle 5 with N_IN=2) must abort and clear everything.
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.train_i     = 1'b1;
        bus.is_output_i = 1'b1;
        bus.x_in_i      = {32'h0, 32'h0001_0000};
        bus.target_i    = 32'h0001_0000;
        bus.step_i      = 32'h0001_0000;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        checkOutput("rstUpd.busyBefore", 64'(bus.busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstUpd.busy", 64'(bus.busy_o), 64'd0);
        checkOutput("rstUpd.done", 64'(bus.done_o), 64'd0);
        checkOutput("rstUpd.y", 64'(bus.y_o), 64'd0);
        checkWeights("rstUpd", 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
